// File: rtl/id_stage_if.sv
// id_stage_if: handshake and bus bundle around the glorbcore decode stage.
//   slave  modport : seen by id_stage (consumes fetch/writeback, drives execute side)
//   master modport : seen by the surrounding pipeline / environment
// Signals:
//   in_valid, in_ready, instruction        fetch -> decode handshake
//   out_valid, out_ready, out_rf_we,
//   out_rs1_address, out_rd_address,
//   out_branch_taken                       decode -> execute handshake
//   branch_flag, flush                     execute feedback
//   wb_valid, wb_address                   writeback completion report
//   busy                                   scoreboard bitmap of pending writes
interface id_stage_if #(
  parameter int IW  = 8,
  parameter int RFW = 2
);
  localparam int NREG = 2**RFW;

  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   instruction;
  logic            out_valid;
  logic            out_ready;
  logic            out_rf_we;
  logic [RFW-1:0]  out_rs1_address;
  logic [RFW-1:0]  out_rd_address;
  logic            out_branch_taken;
  logic            branch_flag;
  logic            flush;
  logic            wb_valid;
  logic [RFW-1:0]  wb_address;
  logic [NREG-1:0] busy;

  modport slave (
    input  in_valid, instruction, out_ready, branch_flag, flush, wb_valid, wb_address,
    output in_ready, out_valid, out_rf_we, out_rs1_address, out_rd_address,
           out_branch_taken, busy
  );

  modport master (
    output in_valid, instruction, out_ready, branch_flag, flush, wb_valid, wb_address,
    input  in_ready, out_valid, out_rf_we, out_rs1_address, out_rd_address,
           out_branch_taken, busy
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: registered, handshaked instruction-decode stage.
//   Decodes rs1/rd/type from the incoming word, holds the result in an output
//   register with valid/ready flow control, resolves conditional branches and
//   supports flush. With ID_SCOREBOARD_EN defined, a register scoreboard stalls
//   RAW/WAW hazards; otherwise busy is tied low and writeback is ignored.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  id_stage_if.slave (fetch, execute, writeback and busy signals)
// Configuration macro: ID_SCOREBOARD_EN
module id_stage #(
  parameter int IW  = 8,
  parameter int RFW = 2
) (
  input logic        clk,
  input logic        rst,
  id_stage_if.slave  bus
);
  localparam int NREG = 2**RFW;

  logic [RFW-1:0] dec_rs1;
  logic [RFW-1:0] dec_rd;
  logic           dec_b_type;
  logic           dec_rf_we;
  logic           dec_taken;
  logic           hazard;
  logic           accept;
  logic           issue;

  logic           out_valid_q, out_valid_d;
  logic           out_rf_we_q, out_rf_we_d;
  logic [RFW-1:0] out_rs1_q, out_rs1_d;
  logic [RFW-1:0] out_rd_q, out_rd_d;
  logic           out_taken_q, out_taken_d;

  assign dec_rs1    = bus.instruction[IW-1 -: RFW];
  assign dec_rd     = bus.instruction[IW-1-RFW -: RFW];
  assign dec_b_type = bus.instruction[0];
  assign dec_rf_we  = !dec_b_type && (dec_rd != '0);
  assign dec_taken  = dec_b_type && (!bus.instruction[1] || bus.branch_flag);

  assign issue  = out_valid_q && bus.out_ready && !bus.flush;

`ifdef ID_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;

  // busy_q is registered, so a writeback clear only unblocks the cycle after.
  // A held writer that is issuing this cycle still blocks its dependants.
  always_comb begin
    hazard = 1'b0;
    if (dec_rs1 != '0 && busy_q[dec_rs1])
      hazard = 1'b1;
    if (dec_rf_we && busy_q[dec_rd])
      hazard = 1'b1;
    if (out_valid_q && out_rf_we_q &&
        ((dec_rs1 != '0 && out_rd_q == dec_rs1) || (dec_rf_we && out_rd_q == dec_rd)))
      hazard = 1'b1;
  end

  // Clear first, then set, so an issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid && bus.wb_address != '0)
      busy_d[bus.wb_address] = 1'b0;
    if (issue && out_rf_we_q)
      busy_d[out_rd_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign bus.busy = busy_q;
`else
  logic unused_wb;
  assign unused_wb = bus.wb_valid ^ (^bus.wb_address);
  assign hazard    = 1'b0;
  assign bus.busy  = '0;
`endif

  assign bus.in_ready = !rst && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Held fields only change on accept; a plain issue or flush drops valid only.
  always_comb begin
    out_valid_d = out_valid_q;
    out_rf_we_d = out_rf_we_q;
    out_rs1_d   = out_rs1_q;
    out_rd_d    = out_rd_q;
    out_taken_d = out_taken_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_rf_we_d = dec_rf_we;
      out_rs1_d   = dec_rs1;
      out_rd_d    = dec_rd;
      out_taken_d = dec_taken;
    end else if (out_valid_q && (bus.out_ready || bus.flush)) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_rf_we_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rd_q    <= '0;
      out_taken_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rf_we_q <= out_rf_we_d;
      out_rs1_q   <= out_rs1_d;
      out_rd_q    <= out_rd_d;
      out_taken_q <= out_taken_d;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.out_rf_we        = out_rf_we_q;
  assign bus.out_rs1_address  = out_rs1_q;
  assign bus.out_rd_address   = out_rd_q;
  assign bus.out_branch_taken = out_taken_q;
endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
  localparam int IW   = 8;
  localparam int RFW  = 2;
  localparam int NREG = 2**RFW;
`ifdef ID_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if #(.IW(IW), .RFW(RFW)) bus();
  id_stage #(.IW(IW), .RFW(RFW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the held decoded instruction and pending writes.
  bit h_valid, h_we, h_taken;
  int h_rs1, h_rd;
  bit pend [NREG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    h_valid = 0; h_we = 0; h_taken = 0; h_rs1 = 0; h_rd = 0;
    for (int i = 0; i < NREG; i++) pend[i] = 0;
  endtask

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic step(input int ins, input bit iv, input bit ordy, input bit flag,
                      input bit fl, input bit wbv, input int wba, input bit r);
    int rs1, rd;
    bit wr, tk, hz, exp_rdy, acc, iss;
    logic [NREG-1:0] eb;
    rst = r;
    bus.in_valid = iv; bus.instruction = ins[IW-1:0]; bus.out_ready = ordy;
    bus.branch_flag = flag; bus.flush = fl; bus.wb_valid = wbv; bus.wb_address = wba[RFW-1:0];
    rs1 = ins / (2**(IW-RFW));
    rd  = (ins / (2**(IW-2*RFW))) % NREG;
    wr  = (ins % 2 == 0) && (rd != 0);
    tk  = (ins % 2 == 1) && (((ins / 2) % 2 == 0) || flag);
    hz  = 0;
    if (SB) begin
      if (rs1 != 0 && pend[rs1]) hz = 1;
      if (wr && pend[rd]) hz = 1;
      if (h_valid && h_we && ((rs1 != 0 && h_rd == rs1) || (wr && h_rd == rd))) hz = 1;
    end
    exp_rdy = !r && !fl && !hz && (!h_valid || ordy);
    eb = '0;
    for (int i = 1; i < NREG; i++) if (SB && pend[i]) eb[i] = 1'b1;
    #1;
    check("in_ready",  32'(bus.in_ready),         32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid),        32'(h_valid));
    check("out_rf_we", 32'(bus.out_rf_we),        32'(h_we));
    check("out_rs1",   32'(bus.out_rs1_address),  h_rs1);
    check("out_rd",    32'(bus.out_rd_address),   h_rd);
    check("out_taken", 32'(bus.out_branch_taken), 32'(h_taken));
    check("busy",      32'(bus.busy),             32'(eb));
    acc = iv && exp_rdy;
    iss = h_valid && ordy && !fl;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (wbv && wba != 0) pend[wba] = 0;
      if (iss && h_we) pend[h_rd] = 1;
      if (acc) begin
        h_valid = 1; h_we = wr; h_rs1 = rs1; h_rd = rd; h_taken = tk;
      end else if (h_valid && (ordy || fl)) begin
        h_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, ordy, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.instruction = '0; bus.out_ready = 0; bus.branch_flag = 0;
    bus.flush = 0; bus.wb_valid = 0; bus.wb_address = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step(0, 1, 1, 0, 0, 0, 0, 1);
    check("reset_busy",  32'(bus.busy), 0);
    check("reset_valid", 32'(bus.out_valid), 0);

    // Streaming writer rs1=1 rd=2, then issue sets busy[2].
    step(8'h60, 1, 1, 0, 0, 0, 0, 0);
    check("stream_rd", 32'(bus.out_rd_address), 2);
    idle(1);
    check("busy_after_issue", 32'(bus.busy), SB ? 32'h4 : 32'h0);

    // RAW on r2: stalls until the cycle after writeback of r2.
    step(8'h90, 1, 1, 0, 0, 0, 0, 0);
    step(8'h90, 1, 1, 0, 0, 0, 0, 0);
    step(8'h90, 1, 1, 0, 0, 1, 2, 0);
    step(8'h90, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    idle(1);

    // rd=0 R-type, with r0 "written back" as noise.
    step(8'h00, 1, 1, 0, 0, 1, 0, 0);
    step(8'h40, 1, 1, 0, 0, 0, 0, 0);
    check("rd0_no_we", 32'(bus.out_rf_we), 0);

    // Branches.
    step(8'h01, 1, 1, 0, 0, 0, 0, 0);
    check("br_uncond", 32'(bus.out_branch_taken), 1);
    step(8'h03, 1, 1, 0, 0, 0, 0, 0);
    check("br_cond_f0", 32'(bus.out_branch_taken), 0);
    step(8'h03, 1, 1, 1, 0, 0, 0, 0);
    check("br_cond_f1", 32'(bus.out_branch_taken), 1);
    idle(1);
    step(0, 0, 1, 0, 0, 1, 1, 0);
    idle(1);

    // Backpressure for 3 cycles, then flush.
    step(8'h70, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(8'h40, 1, 0, 0, 0, 0, 0, 0);
    step(8'h40, 1, 0, 0, 1, 0, 0, 0);
    check("flush_valid", 32'(bus.out_valid), 0);
    idle(1);

    // Writeback of r3 in the same cycle as issue of a writer to r3.
    step(8'h30, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 3, 0);
    check("wb_set_wins", 32'(bus.busy[3]), 32'(SB));

    // Reset in the middle of a stall.
    step(8'h10, 1, 0, 0, 0, 0, 0, 0);
    step(8'h50, 1, 0, 0, 0, 0, 0, 0);
    step(8'h50, 1, 0, 0, 0, 0, 0, 1);
    check("rst_stall_busy",  32'(bus.busy), 0);
    check("rst_stall_valid", 32'(bus.out_valid), 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(int'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 7),
           $urandom_range(0, 1),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 4),
           int'($urandom_range(0, NREG-1)),
           ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
